// File: rtl/div_seq_if.sv
// Run/stall handshake and operand/result bus between the core and the sequential divider.
interface div_seq_if #(
   parameter int WIDTH = 32
);
   logic             run;
   logic             u;
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] y;
   logic             stall;
   logic [WIDTH-1:0] quot;
   logic [WIDTH-1:0] rem;

   modport master (output run, u, x, y, input stall, quot, rem);
   modport slave  (input run, u, x, y, output stall, quot, rem);
endinterface

// File: rtl/div_seq.sv
// Radix-2 restoring divider, one quotient bit per clock, floor-division results
// for a signed or unsigned dividend over an unsigned divisor.
module div_seq #(
   parameter int WIDTH = 32,
   parameter int CW    = 6
) (
   input  logic       clk,
   input  logic       rst,
   div_seq_if.slave   bus
);
   localparam logic [CW-1:0] CNT_DONE = CW'(WIDTH + 1);

   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] y_q, y_d;
   logic [WIDTH-1:0] x_q, x_d;
   logic             neg_q, neg_d;
   logic             div0_q, div0_d;

   logic [WIDTH+1:0] trial;
   logic [WIDTH:0]   shifted;

   // {r, a_msb} never exceeds 2*y, so two guard bits cover the sign of the trial subtract.
   assign shifted = {r_q, a_q[WIDTH-1]};
   assign trial   = {1'b0, shifted} - {2'b00, y_q};

   always_comb begin
      cnt_d  = cnt_q;
      a_d    = a_q;
      r_d    = r_q;
      q_d    = q_q;
      y_d    = y_q;
      x_d    = x_q;
      neg_d  = neg_q;
      div0_d = div0_q;
      if (!bus.run) begin
         cnt_d = '0;
      end else if (cnt_q == '0) begin
         neg_d  = ~bus.u & bus.x[WIDTH-1];
         a_d    = neg_d ? (~bus.x + WIDTH'(1)) : bus.x;
         x_d    = bus.x;
         y_d    = bus.y;
         div0_d = (bus.y == '0);
         r_d    = '0;
         q_d    = '0;
         cnt_d  = cnt_q + CW'(1);
      end else if (cnt_q != CNT_DONE) begin
         if (!trial[WIDTH+1]) begin
            r_d = trial[WIDTH-1:0];
            q_d = {q_q[WIDTH-2:0], 1'b1};
         end else begin
            r_d = shifted[WIDTH-1:0];
            q_d = {q_q[WIDTH-2:0], 1'b0};
         end
         a_d   = {a_q[WIDTH-2:0], 1'b0};
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q  <= '0;
         a_q    <= '0;
         r_q    <= '0;
         q_q    <= '0;
         y_q    <= '0;
         x_q    <= '0;
         neg_q  <= 1'b0;
         div0_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         a_q    <= a_d;
         r_q    <= r_d;
         q_q    <= q_d;
         y_q    <= y_d;
         x_q    <= x_d;
         neg_q  <= neg_d;
         div0_q <= div0_d;
      end
   end

   assign bus.stall = bus.run & (cnt_q != CNT_DONE);

   // A negative dividend with nonzero remainder rounds the quotient down one more step.
   always_comb begin
      bus.quot = q_q;
      bus.rem  = r_q;
      if (div0_q) begin
         bus.quot = '1;
         bus.rem  = x_q;
      end else if (neg_q) begin
         if (r_q == '0) begin
            bus.quot = ~q_q + WIDTH'(1);
            bus.rem  = '0;
         end else begin
            bus.quot = ~q_q;
            bus.rem  = y_q - r_q;
         end
      end
   end
endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: floor-division reference model feeding a result queue.
module tb_div_seq;
   localparam int W = 32;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;

   typedef struct {
      logic [W-1:0] quot;
      logic [W-1:0] rem;
   } res_t;
   res_t sb[$];

   div_seq_if #(.WIDTH(W)) bus ();
   div_seq #(.WIDTH(W), .CW(6)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic res_t model(input logic u, input logic [W-1:0] x, input logic [W-1:0] y);
      res_t   r;
      longint sx, sy, q, m;
      if (y == '0) begin
         r.quot = '1;
         r.rem  = x;
      end else begin
         sx = u ? longint'({32'h0, x}) : longint'(signed'(x));
         sy = longint'({32'h0, y});
         q  = sx / sy;
         m  = sx % sy;
         if (m < 0) begin
            q = q - 1;
            m = m + sy;
         end
         r.quot = q[W-1:0];
         r.rem  = m[W-1:0];
      end
      return r;
   endfunction

   // Called at a negedge with run already high; counts stall cycles and checks the result.
   task automatic wait_done(input string tag, input bit scramble);
      int   n = 0;
      res_t e;
      #1;
      while (bus.stall === 1'b1 && n < 100) begin
         n++;
         @(negedge clk);
         if (scramble) begin
            bus.x = $urandom;
            bus.y = $urandom;
         end
         #1;
      end
      check({tag, "_stall_cycles"}, W'(n), W'(33));
      if (sb.size() == 0) begin
         check({tag, "_sb_empty"}, 32'h1, 32'h0);
      end else begin
         e = sb.pop_front();
         check({tag, "_quot"}, bus.quot, e.quot);
         check({tag, "_rem"}, bus.rem, e.rem);
      end
   endtask

   task automatic start(input logic u, input logic [W-1:0] x, input logic [W-1:0] y);
      @(negedge clk);
      bus.u   = u;
      bus.x   = x;
      bus.y   = y;
      bus.run = 1'b1;
   endtask

   task automatic do_op(input string tag, input logic u, input logic [W-1:0] x,
                        input logic [W-1:0] y, input bit scramble);
      start(u, x, y);
      sb.push_back(model(u, x, y));
      wait_done(tag, scramble);
   endtask

   task automatic end_op();
      @(negedge clk);
      bus.run = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      res_t hold;
      bus.run = 1'b0;
      bus.u   = 1'b1;
      bus.x   = '0;
      bus.y   = '0;
      #12;
      check("reset_quot", bus.quot, '0);
      check("reset_rem", bus.rem, '0);
      check("reset_stall_idle", W'(bus.stall), W'(0));
      bus.run = 1'b1;
      #1;
      check("reset_stall_run", W'(bus.stall), W'(1));
      bus.run = 1'b0;
      @(negedge clk);
      rst = 1'b1;

      // basic unsigned op, then result must stay put for 5 more cycles
      do_op("u100_7", 1'b1, 100, 7, 1'b0);
      hold.quot = 14;
      hold.rem  = 2;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("hold_quot", bus.quot, hold.quot);
         check("hold_rem", bus.rem, hold.rem);
         check("hold_stall", W'(bus.stall), W'(0));
      end
      end_op();

      do_op("s_m7_2", 1'b0, 32'hFFFF_FFF9, 2, 1'b0);           end_op();
      do_op("s_m8_2", 1'b0, 32'hFFFF_FFF8, 2, 1'b0);           end_op();
      do_op("u_fff9_2", 1'b1, 32'hFFFF_FFF9, 2, 1'b0);         end_op();
      do_op("u_max_1", 1'b1, 32'hFFFF_FFFF, 1, 1'b0);          end_op();
      do_op("s_min_1", 1'b0, 32'h8000_0000, 1, 1'b0);          end_op();
      do_op("u_5_big", 1'b1, 5, 32'h8000_0000, 1'b0);          end_op();
      do_op("s_div0", 1'b0, 32'h1234_5678, 0, 1'b0);           end_op();
      do_op("u_div0", 1'b1, 32'h1234_5678, 0, 1'b0);           end_op();
      do_op("s_m100_7", 1'b0, 32'hFFFF_FF9C, 7, 1'b0);         end_op();
      do_op("s_neg_bigy", 1'b0, 32'hFFFF_FFFB, 32'h9000_0000, 1'b0); end_op();

      // abort after 10 cycles, restart with fresh operands
      start(1'b1, 100, 7);
      repeat (10) @(negedge clk);
      bus.run = 1'b0;
      @(negedge clk);
      do_op("restart_9_4", 1'b1, 9, 4, 1'b0);
      end_op();

      // async reset mid-operation, run kept high across release
      start(1'b1, 100, 7);
      repeat (20) @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      check("rst_mid_quot", bus.quot, '0);
      check("rst_mid_rem", bus.rem, '0);
      bus.x = 32'd1000;
      bus.y = 32'd33;
      sb.push_back(model(1'b1, 32'd1000, 32'd33));
      @(negedge clk);
      rst = 1'b1;
      wait_done("after_rst", 1'b0);
      end_op();

      // back-to-back with operand scrambling after each load edge
      do_op("b2b_a", 1'b0, 32'hFFFF_1234, 32'd97, 1'b1);
      @(negedge clk);
      bus.run = 1'b0;
      do_op("b2b_b", 1'b1, 32'hDEAD_BEEF, 32'd12345, 1'b1);
      end_op();
      for (int i = 0; i < 4; i++) begin
         logic [W-1:0] rx, ry;
         logic         ru;
         rx = $urandom;
         ry = $urandom_range(1, 32'hFFFF);
         ru = 1'(i);
         do_op("rand", ru, rx, ry, 1'b1);
         end_op();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end
endmodule
